shift_operand_stage: RTL and testbench
======================================

Name: shift_operand_stage

Overview:
- Pipeline stage directly upstream of the 16-bit barrel shifter. It accepts shift requests over a valid/ready handshake and normalises register-sourced shift amounts.
- Drives registered ShiftSelect, ShifterAmount and OriginB straight into the shifter's inputs.
- A 2-entry skid buffer keeps InReady registered, so a stalled downstream never creates a combinational ready path.

Parameters:
- DATA_WIDTH, 16, operand width; only 16 is supported.
- AMT_WIDTH, 4, shift-amount width; must equal log2(DATA_WIDTH).

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Rst  input  1  synchronous, active-high reset.
- InValid  input  1  upstream request valid.
- InReady  output  1  stage can accept a request; registered.
- InSelect  input  3  shift op: 000 LSR, 001 LSL, 010 ROR, 011 ROL, 100 ASR, 101–111 illegal.
- InAmtFromReg  input  1  1 = amount from InRegAmt, 0 = amount from InImm.
- InImm  input  4  immediate shift amount.
- InRegAmt  input  16  register-sourced shift amount (full value).
- InOperandB  input  16  operand to be shifted.
- OutValid  output  1  registered outputs hold a valid request.
- OutReady  input  1  downstream (shifter/ALU writeback) accepts the request.
- ShiftSelect  output  3  to the shifter.
- ShifterAmount  output  4  to the shifter.
- OriginB  output  16  to the shifter.
- IllegalOp  output  1  the held request had InSelect 101–111.
- AcceptCount  output  16  number of requests accepted since reset; wraps.

Behaviour:
- Reset (Rst=1 at an edge): OutValid=0, InReady=1, ShiftSelect=000, ShifterAmount=0, OriginB=0, IllegalOp=0, AcceptCount=0. Skid entry is invalidated. Reset mid-operation drops both held entries; no request is replayed.
- Transfers: accept occurs when InValid&InReady; emit occurs when OutValid&OutReady.
- Normalisation is applied at accept, before storage. Let A = InAmtFromReg ? InRegAmt : zero-extended InImm.
  - A < 16: ShifterAmount = A[3:0], OriginB = InOperandB, for every op.
  - A >= 16, LSR/LSL: OriginB = 0, ShifterAmount = 0, ShiftSelect unchanged. The shifter then yields 0.
  - A >= 16, ROR/ROL: ShifterAmount = A[3:0] (mod 16), OriginB unchanged.
  - A >= 16, ASR: ShifterAmount = 15, OriginB unchanged. The result is sign-fill.
  - Illegal select: fields pass through unmodified, IllegalOp=1. The shifter produces 0.
  - An immediate amount is never >= 16.
- Buffer: main output register plus one skid register. States: EMPTY (OutValid=0), ONE (main valid, skid empty), FULL (both valid).
  - EMPTY + accept → ONE. The request is loaded into main; OutValid=1 on the next cycle (latency 1).
  - ONE + accept + emit → ONE. Main is reloaded with the new request.
  - ONE + accept, no emit → FULL. The request goes to skid; InReady=0 from the next cycle.
  - ONE + emit, no accept → EMPTY.
  - FULL + emit → ONE. Skid moves to main; InReady=1 next cycle. No accept is possible while FULL.
  - FULL, no emit → hold all outputs stable.
- InReady = !skid_valid, registered. It is never dependent on OutReady in the same cycle.
- Outputs hold stable while OutValid&!OutReady (AXI-style; no retraction).
- Ordering is strictly FIFO; zero bubbles under continuous InValid and OutReady (one transfer per cycle).
- AcceptCount increments by 1 on each accept and wraps 0xFFFF→0x0000.
- Inputs are ignored when InReady=0. OutReady is ignored when OutValid=0.

Test Plan:
- Reset then single LSL: InSelect=001, InImm=3, InOperandB=0x00F1, OutReady=1. → OutValid=1 exactly one cycle later, ShiftSelect=001, ShifterAmount=3, OriginB=0x00F1. AcceptCount=1.
- Over-shift normalisation: InAmtFromReg=1, InRegAmt=20.
  - LSR on 0xFFFF → OriginB=0, ShifterAmount=0.
  - ROL on 0x1234 → ShifterAmount=4, OriginB=0x1234.
  - ASR on 0x8000 → ShifterAmount=15.
- Backpressure: OutReady=0, push three requests back-to-back. → First two accepted (main, skid); InReady=0 after the second, third held off. Raise OutReady → outputs emit in order 1,2,3 with no duplicates and no drops.
- Streaming: 100 random requests with InValid=1, OutReady=1 throughout. → 100 outputs in 101 cycles, in order, each matching the normalisation model. AcceptCount=100.
- Illegal op and reset mid-operation: InSelect=110 → IllegalOp=1, fields unmodified. Fill to FULL, assert Rst for one cycle → OutValid=0, InReady=1, AcceptCount=0, and no stale request appears afterwards.

Source files
------------

// File: rtl/shift_operand_stage.sv
// Purpose: normalises shift requests (op, amount, operand) and holds them for the 16-bit barrel shifter.
// Latency: one cycle from accept to OutValid; one transfer per cycle when streaming.
// Backpressure: 2-entry skid buffer, InReady comes straight from the skid-valid flop and never from OutReady.
module shift_operand_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int AMT_WIDTH  = 4
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [2:0]            InSelect,
  input  logic                  InAmtFromReg,
  input  logic [AMT_WIDTH-1:0]  InImm,
  input  logic [DATA_WIDTH-1:0] InRegAmt,
  input  logic [DATA_WIDTH-1:0] InOperandB,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [2:0]            ShiftSelect,
  output logic [AMT_WIDTH-1:0]  ShifterAmount,
  output logic [DATA_WIDTH-1:0] OriginB,
  output logic                  IllegalOp,
  output logic [15:0]           AcceptCount
);

  localparam logic [2:0] SelLsr = 3'b000;
  localparam logic [2:0] SelLsl = 3'b001;
  localparam logic [2:0] SelAsr = 3'b100;

  // One normalised request as stored in either buffer slot.
  typedef struct packed {
    logic [2:0]            sel;
    logic [AMT_WIDTH-1:0]  amt;
    logic [DATA_WIDTH-1:0] opB;
    logic                  illegal;
  } shiftReq_t;

  shiftReq_t             newReq;
  shiftReq_t             mainQ;
  shiftReq_t             skidQ;
  logic                  mainVld;
  logic                  skidVld;
  logic [15:0]           acceptCnt;
  logic [DATA_WIDTH-1:0] rawAmt;
  logic                  overShift;
  logic                  accept;
  logic                  emit;

  assign accept = InValid & InReady;
  assign emit   = mainVld & OutReady;

  // Normalise the incoming request so the shifter never sees an amount >= width.
  always_comb begin
    rawAmt         = InAmtFromReg ? InRegAmt
                                  : {{(DATA_WIDTH-AMT_WIDTH){1'b0}}, InImm};
    overShift      = |rawAmt[DATA_WIDTH-1:AMT_WIDTH];
    newReq.sel     = InSelect;
    newReq.amt     = rawAmt[AMT_WIDTH-1:0];
    newReq.opB     = InOperandB;
    newReq.illegal = (InSelect > SelAsr);
    if (!newReq.illegal && overShift) begin
      case (InSelect)
        // Logical over-shift: zero operand with zero amount gives a zero result.
        SelLsr, SelLsl: begin
          newReq.amt = '0;
          newReq.opB = '0;
        end
        // Arithmetic over-shift saturates to a full sign-fill.
        SelAsr: newReq.amt = '1;
        // Rotates keep amount modulo width, which is already the low bits.
        default: ;
      endcase
    end
  end

  // Main/skid buffer: EMPTY, ONE (main only) and FULL (main + skid), strictly FIFO.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      mainVld   <= 1'b0;
      skidVld   <= 1'b0;
      mainQ     <= '0;
      skidQ     <= '0;
      acceptCnt <= '0;
    end else begin
      if (accept) begin
        acceptCnt <= acceptCnt + 16'd1;
      end
      if (!mainVld) begin
        if (accept) begin
          mainQ   <= newReq;
          mainVld <= 1'b1;
        end
      end else if (!skidVld) begin
        if (accept && emit) begin
          mainQ <= newReq;
        end else if (accept) begin
          skidQ   <= newReq;
          skidVld <= 1'b1;
        end else if (emit) begin
          mainVld <= 1'b0;
        end
      end else if (emit) begin
        // Skid drains into main; no accept is possible while both are full.
        mainQ   <= skidQ;
        skidVld <= 1'b0;
      end
    end
  end

  assign InReady       = ~skidVld;
  assign OutValid      = mainVld;
  assign ShiftSelect   = mainQ.sel;
  assign ShifterAmount = mainQ.amt;
  assign OriginB       = mainQ.opB;
  assign IllegalOp     = mainQ.illegal;
  assign AcceptCount   = acceptCnt;

endmodule

// File: tb/tb_shift_operand_stage.sv
// Purpose: self-checking bench for shift_operand_stage (table vectors, handshake corners, random stream).
// Latency: expects OutValid one cycle after accept.
// Backpressure: exercises OutReady low with the skid buffer full.
module tb_shift_operand_stage;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        InValid;
  logic        InReady;
  logic [2:0]  InSelect;
  logic        InAmtFromReg;
  logic [3:0]  InImm;
  logic [15:0] InRegAmt;
  logic [15:0] InOperandB;
  logic        OutValid;
  logic        OutReady;
  logic [2:0]  ShiftSelect;
  logic [3:0]  ShifterAmount;
  logic [15:0] OriginB;
  logic        IllegalOp;
  logic [15:0] AcceptCount;

  shift_operand_stage #(.DATA_WIDTH(16), .AMT_WIDTH(4)) dut (
    .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(InReady),
    .InSelect(InSelect), .InAmtFromReg(InAmtFromReg), .InImm(InImm),
    .InRegAmt(InRegAmt), .InOperandB(InOperandB), .OutValid(OutValid),
    .OutReady(OutReady), .ShiftSelect(ShiftSelect), .ShifterAmount(ShifterAmount),
    .OriginB(OriginB), .IllegalOp(IllegalOp), .AcceptCount(AcceptCount)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [2:0]  sel;
    logic [3:0]  amt;
    logic [15:0] opB;
    logic        ill;
  } out_t;

  typedef struct {
    logic [2:0]  sel;
    logic        fromReg;
    logic [3:0]  imm;
    logic [15:0] regAmt;
    logic [15:0] opB;
    out_t        exp;
  } vec_t;

  out_t sbQ[$];
  int   errors = 0;
  int   checks = 0;
  int   accepted = 0;
  int   emitted = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: amount A from register or immediate, then the over-shift rules per op.
  function automatic out_t model(input logic [2:0] sel, input logic fromReg, input logic [3:0] imm,
                                 input logic [15:0] regAmt, input logic [15:0] opB);
    int   a;
    out_t r;
    a     = fromReg ? int'(regAmt) : int'(imm);
    r.sel = sel;
    r.ill = (sel > 3'd4);
    r.opB = opB;
    r.amt = 4'(a % 16);
    if (!r.ill && a >= 16) begin
      if (sel <= 3'd1) begin
        r.amt = 4'd0;
        r.opB = 16'd0;
      end else if (sel == 3'd4) begin
        r.amt = 4'd15;
      end
    end
    return r;
  endfunction

  // Inputs are already set; record emit/accept for this edge, then advance one cycle.
  task automatic tick();
    out_t act;
    act = {ShiftSelect, ShifterAmount, OriginB, IllegalOp};
    if (OutValid === 1'b1 && OutReady && !Rst) begin
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL emit_unexpected: got 0x%0h expected no output", act);
      end else begin
        chk("emit_order", act, sbQ.pop_front());
      end
      emitted++;
    end
    if (InValid && InReady === 1'b1 && !Rst) begin
      sbQ.push_back(model(InSelect, InAmtFromReg, InImm, InRegAmt, InOperandB));
      accepted++;
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic setReq(input logic [2:0] sel, input logic fromReg, input logic [3:0] imm,
                        input logic [15:0] regAmt, input logic [15:0] opB);
    InSelect     = sel;
    InAmtFromReg = fromReg;
    InImm        = imm;
    InRegAmt     = regAmt;
    InOperandB   = opB;
  endtask

  task automatic doReset();
    InValid  = 1'b0;
    OutReady = 1'b0;
    Rst      = 1'b1;
    tick();
    Rst = 1'b0;
    sbQ.delete();
    accepted = 0;
    emitted  = 0;
  endtask

  vec_t vecs[13];

  initial begin
    int acc0;
    int stalls;
    vecs[0]  = '{3'b001, 1'b0, 4'd3,  16'h0000, 16'h00F1, '{3'b001, 4'd3,  16'h00F1, 1'b0}};
    vecs[1]  = '{3'b000, 1'b1, 4'd0,  16'd20,   16'hFFFF, '{3'b000, 4'd0,  16'h0000, 1'b0}};
    vecs[2]  = '{3'b011, 1'b1, 4'd0,  16'd20,   16'h1234, '{3'b011, 4'd4,  16'h1234, 1'b0}};
    vecs[3]  = '{3'b100, 1'b1, 4'd0,  16'd20,   16'h8000, '{3'b100, 4'd15, 16'h8000, 1'b0}};
    vecs[4]  = '{3'b010, 1'b1, 4'd0,  16'd16,   16'hABCD, '{3'b010, 4'd0,  16'hABCD, 1'b0}};
    vecs[5]  = '{3'b001, 1'b1, 4'd0,  16'd15,   16'h0001, '{3'b001, 4'd15, 16'h0001, 1'b0}};
    vecs[6]  = '{3'b001, 1'b1, 4'd0,  16'd16,   16'h0001, '{3'b001, 4'd0,  16'h0000, 1'b0}};
    vecs[7]  = '{3'b100, 1'b1, 4'd0,  16'hFFFF, 16'h7FFF, '{3'b100, 4'd15, 16'h7FFF, 1'b0}};
    vecs[8]  = '{3'b110, 1'b0, 4'd5,  16'h0000, 16'h5A5A, '{3'b110, 4'd5,  16'h5A5A, 1'b1}};
    vecs[9]  = '{3'b111, 1'b1, 4'd0,  16'd20,   16'h1111, '{3'b111, 4'd4,  16'h1111, 1'b1}};
    vecs[10] = '{3'b010, 1'b1, 4'd0,  16'h0103, 16'h00FF, '{3'b010, 4'd3,  16'h00FF, 1'b0}};
    vecs[11] = '{3'b100, 1'b1, 4'd0,  16'd10,   16'h8000, '{3'b100, 4'd10, 16'h8000, 1'b0}};
    vecs[12] = '{3'b000, 1'b0, 4'd7,  16'hFFFF, 16'hC3C3, '{3'b000, 4'd7,  16'hC3C3, 1'b0}};

    setReq(3'b000, 1'b0, 4'd0, 16'd0, 16'd0);
    doReset();
    chk("rst_outvalid", 32'(OutValid), 0);
    chk("rst_inready", 32'(InReady), 1);
    chk("rst_select", 32'(ShiftSelect), 0);
    chk("rst_amount", 32'(ShifterAmount), 0);
    chk("rst_originb", 32'(OriginB), 0);
    chk("rst_illegal", 32'(IllegalOp), 0);
    chk("rst_count", 32'(AcceptCount), 0);

    // Table vectors: one request each, checked one cycle after accept, then drained.
    for (int i = 0; i < 13; i++) begin
      setReq(vecs[i].sel, vecs[i].fromReg, vecs[i].imm, vecs[i].regAmt, vecs[i].opB);
      InValid  = 1'b1;
      OutReady = 1'b1;
      chk("vec_pre_valid", 32'(OutValid), 0);
      tick();
      InValid = 1'b0;
      chk("vec_lat1_valid", 32'(OutValid), 1);
      chk("vec_fields", 32'({ShiftSelect, ShifterAmount, OriginB, IllegalOp}), 32'(vecs[i].exp));
      chk("vec_count", 32'(AcceptCount), 32'(i + 1));
      tick();
    end

    // Backpressure: two accepted into main/skid, third held off until drain.
    OutReady = 1'b0;
    acc0     = accepted;
    InValid  = 1'b1;
    setReq(3'b001, 1'b0, 4'd1, 16'd0, 16'h0001);
    tick();
    chk("bp_ready_one", 32'(InReady), 1);
    setReq(3'b000, 1'b0, 4'd2, 16'd0, 16'h0002);
    tick();
    chk("bp_ready_full", 32'(InReady), 0);
    setReq(3'b010, 1'b0, 4'd3, 16'd0, 16'h0003);
    tick();
    chk("bp_ready_held", 32'(InReady), 0);
    chk("bp_hold_originb", 32'(OriginB), 32'h0001);
    chk("bp_accepts_held", 32'(accepted - acc0), 2);
    OutReady = 1'b1;
    for (int k = 0; k < 20 && !(accepted == acc0 + 3 && sbQ.size() == 0); k++) begin
      if (accepted == acc0 + 3) InValid = 1'b0;
      tick();
    end
    InValid = 1'b0;
    chk("bp_drain", 32'(sbQ.size()), 0);
    chk("bp_accepts", 32'(accepted - acc0), 3);
    tick();
    chk("bp_empty_after", 32'(OutValid), 0);

    // Random stream: 100 requests, 101 cycles, no stalls.
    doReset();
    OutReady = 1'b1;
    stalls   = 0;
    for (int c = 0; c < 101; c++) begin
      if (accepted < 100) begin
        InValid      = 1'b1;
        InSelect     = 3'($urandom_range(0, 7));
        InAmtFromReg = 1'($urandom_range(0, 1));
        InImm        = 4'($urandom_range(0, 15));
        case ($urandom_range(0, 2))
          0:       InRegAmt = 16'($urandom_range(0, 15));
          1:       InRegAmt = 16'($urandom_range(16, 40));
          default: InRegAmt = 16'($urandom);
        endcase
        InOperandB = 16'($urandom);
      end else begin
        InValid = 1'b0;
      end
      if (InReady !== 1'b1) stalls++;
      tick();
    end
    chk("stream_emitted", 32'(emitted), 100);
    chk("stream_count", 32'(AcceptCount), 100);
    chk("stream_stalls", 32'(stalls), 0);
    chk("stream_sb_empty", 32'(sbQ.size()), 0);

    // Reset while FULL: both entries dropped, nothing replayed.
    OutReady = 1'b0;
    InValid  = 1'b1;
    setReq(3'b100, 1'b1, 4'd0, 16'd3, 16'h8001);
    tick();
    setReq(3'b011, 1'b0, 4'd9, 16'd0, 16'h4242);
    tick();
    chk("mid_full", 32'(InReady), 0);
    doReset();
    chk("mid_rst_outvalid", 32'(OutValid), 0);
    chk("mid_rst_inready", 32'(InReady), 1);
    chk("mid_rst_count", 32'(AcceptCount), 0);
    OutReady = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("mid_no_stale", 32'(OutValid), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
